// File: rtl/donut_sched_if.sv
// Purpose : bundle of control, ray-setup, marcher and pixel-stream signals for donut_sched.
// Latency : n/a (wires only).
// Backpres: pixel stream uses pix_valid/pix_ready; marcher side has no backpressure.
// Modports: master = scheduler side (drives march_* and pix_*), slave = environment side.
interface donut_sched_if;
    logic               frame_go;
    logic signed [15:0] org_x, org_y, org_z;
    logic signed [15:0] ray_x0, ray_y0, ray_z;
    logic signed [15:0] col_dx, row_dy;
    logic               march_start;
    logic signed [15:0] march_px, march_py, march_pz;
    logic signed [15:0] march_rx, march_ry, march_rz;
    logic               hit;
    logic signed [15:0] light;
    logic               pix_valid;
    logic               pix_ready;
    logic [3:0]         pix_shade;
    logic [7:0]         pix_col;
    logic [7:0]         pix_row;
    logic               busy;
    logic               frame_done;

    modport master (
        input  frame_go, org_x, org_y, org_z, ray_x0, ray_y0, ray_z, col_dx, row_dy,
        input  hit, light, pix_ready,
        output march_start, march_px, march_py, march_pz, march_rx, march_ry, march_rz,
        output pix_valid, pix_shade, pix_col, pix_row, busy, frame_done
    );

    modport slave (
        output frame_go, org_x, org_y, org_z, ray_x0, ray_y0, ray_z, col_dx, row_dy,
        output hit, light, pix_ready,
        input  march_start, march_px, march_py, march_pz, march_rx, march_ry, march_rz,
        input  pix_valid, pix_shade, pix_col, pix_row, busy, frame_done
    );
endinterface

// File: rtl/donut_sched.sv
// Purpose : per-frame pixel scheduler: issues one ray per pixel to a marcher, shades the result, streams pixels.
// Latency : MARCH_CLKS+2 cycles per pixel (START, MARCH_CLKS x MARCH, OUT) when pix_ready is held high.
// Backpres: pix_ready low holds OUT with pix_* stable; no new ray is launched until the pixel transfers.
// Ports   : clk, rst_n (async active-low), bus (donut_sched_if.master: frame setup, marcher strobe/ray, result, pixel stream, status).
// Option  : define DONUT_SCHED_DITHER_EN to add a 2x2 ordered dither to positive light before quantising.
module donut_sched #(
    parameter int COLS       = 40,
    parameter int ROWS       = 24,
    parameter int MARCH_CLKS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    donut_sched_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_MARCH, S_OUT} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic [7:0]  r_col, r_row;
    logic [15:0] r_ray_x0, r_col_dx, r_row_dy;
    logic [15:0] r_px, r_py, r_pz, r_rx, r_ry, r_rz;
    logic [3:0]  r_shade;
    logic        r_frame_done;

    logic        w_last_march, w_xfer, w_last_col, w_last_row;
    logic signed [16:0] w_lt_sum, w_lvl;
    logic [3:0]  w_shade;

    assign w_last_march = (r_cnt == 4'(MARCH_CLKS - 1));
    assign w_xfer       = (r_state == S_OUT) && bus.pix_ready;
    assign w_last_col   = (r_col == 8'(COLS - 1));
    assign w_last_row   = (r_row == 8'(ROWS - 1));

    // Shade quantisation in 17 bits so light near +32767 (plus dither) cannot wrap.
    always_comb begin
        w_lt_sum = {bus.light[15], bus.light};
`ifdef DONUT_SCHED_DITHER_EN
        case ({r_row[0], r_col[0]})
            2'b01:   w_lt_sum = w_lt_sum + 17'sd8;
            2'b10:   w_lt_sum = w_lt_sum + 17'sd12;
            2'b11:   w_lt_sum = w_lt_sum + 17'sd4;
            default: w_lt_sum = w_lt_sum;
        endcase
`endif
        w_lvl = (w_lt_sum >>> 4) + 17'sd1;
        if (!bus.hit)
            w_shade = 4'd0;
        else if (bus.light[15] || (bus.light == 16'sd0))
            w_shade = 4'd1;
        else if (w_lvl > 17'sd15)
            w_shade = 4'd15;
        else
            w_shade = w_lvl[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.frame_go) w_state_nxt = S_START;
            S_START: w_state_nxt = S_MARCH;
            S_MARCH: if (w_last_march) w_state_nxt = S_OUT;
            S_OUT:   if (w_xfer) w_state_nxt = (w_last_col && w_last_row) ? S_IDLE : S_START;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_ray_x0     <= '0;
            r_col_dx     <= '0;
            r_row_dy     <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_pz         <= '0;
            r_rx         <= '0;
            r_ry         <= '0;
            r_rz         <= '0;
            r_shade      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.frame_go) begin
                    r_px     <= bus.org_x;
                    r_py     <= bus.org_y;
                    r_pz     <= bus.org_z;
                    r_rx     <= bus.ray_x0;
                    r_ry     <= bus.ray_y0;
                    r_rz     <= bus.ray_z;
                    r_ray_x0 <= bus.ray_x0;
                    r_col_dx <= bus.col_dx;
                    r_row_dy <= bus.row_dy;
                    r_col    <= '0;
                    r_row    <= '0;
                end
                S_START: r_cnt <= '0;
                S_MARCH: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last_march) r_shade <= w_shade;
                end
                S_OUT: if (bus.pix_ready) begin
                    // Ray is stepped here so it is already valid when START strobes it out.
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 8'd1;
                        r_rx  <= r_ray_x0;
                        r_ry  <= r_ry + r_row_dy;
                    end else begin
                        r_col <= r_col + 8'd1;
                        r_rx  <= r_rx + r_col_dx;
                    end
                    r_frame_done <= w_last_col && w_last_row;
                end
                default: ;
            endcase
        end
    end

    assign bus.march_start = (r_state == S_START);
    assign bus.march_px    = r_px;
    assign bus.march_py    = r_py;
    assign bus.march_pz    = r_pz;
    assign bus.march_rx    = r_rx;
    assign bus.march_ry    = r_ry;
    assign bus.march_rz    = r_rz;
    assign bus.pix_valid   = (r_state == S_OUT);
    assign bus.pix_shade   = r_shade;
    assign bus.pix_col     = r_col;
    assign bus.pix_row     = r_row;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.frame_done  = r_frame_done;

endmodule
